// File: rtl/counter_16.sv
// counter_16: synchronised, edge-detected wrap-around event counter with a registered wrap pulse
module counter_16 #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   wrap_q, wrap_d;
  logic                   inc_s, rise;
  always_comb begin
    sync_d[0] = inc;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    inc_s   = sync_q[SYNC_STAGES-1];
    rise    = inc_s & ~prev_q;
    prev_d  = inc_s;
    count_d = rise ? count_q + 1'b1 : count_q;
    wrap_d  = rise & (&count_q);
  end
  // reset_n keeps its legacy name but is active-high
  always_ff @(posedge clk) begin
    if (reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end
  assign count = count_q;
  assign wrap  = wrap_q;
endmodule

// File: tb/tb_counter_16.sv
// tb_counter_16: vector table plus edge scoreboard for a 16-bit and a 4-bit instance sharing stimulus
module tb_counter_16;
  localparam int SYNC = 2;
  typedef struct {
    int   due;
    logic is_rst;
  } ev_t;
  typedef struct {
    logic        rst;
    logic        inc;
    int          hold;
    logic [15:0] exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        inc = 1'b0;
  logic [15:0] count;
  logic        wrap;
  logic [3:0]  count4;
  logic        wrap4;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        prev_drv = 1'b0;
  logic [15:0] exp_cnt = '0;
  logic        exp_w16 = 1'b0;
  logic        exp_w4 = 1'b0;
  ev_t         q[$];
  vec_t        tbl[11];
  counter_16 #(.WIDTH(16), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .inc(inc), .count(count), .wrap(wrap)
  );
  // narrow instance makes the roll-over reachable within a short run
  counter_16 #(.WIDTH(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .reset_n(reset_n), .inc(inc), .count(count4), .wrap(wrap4)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic r, input logic i, input int h, input logic [15:0] e);
    vec_t v;
    v.rst = r;
    v.inc = i;
    v.hold = h;
    v.exp = e;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  task automatic tick(input logic r, input logic i);
    ev_t e;
    reset_n = r;
    inc = i;
    if (r) begin
      q.delete();
      e.due = cyc + 1;
      e.is_rst = 1'b1;
      q.push_back(e);
      prev_drv = 1'b0;
    end else begin
      if (i && !prev_drv) begin
        e.due = cyc + SYNC + 1;
        e.is_rst = 1'b0;
        q.push_back(e);
      end
      prev_drv = i;
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_w16 = 1'b0;
    exp_w4 = 1'b0;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (e.is_rst) exp_cnt = '0;
      else begin
        exp_cnt++;
        exp_w16 = (exp_cnt == 16'h0000);
        exp_w4 = (exp_cnt[3:0] == 4'h0);
      end
    end
    chk("count", count, exp_cnt);
    chk("wrap", {15'b0, wrap}, {15'b0, exp_w16});
    chk("count4", {12'b0, count4}, {12'b0, exp_cnt[3:0]});
    chk("wrap4", {15'b0, wrap4}, {15'b0, exp_w4});
  endtask
  task automatic pulse();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask
  initial begin
    tbl[0]  = mk(1'b1, 1'b1, 1, 16'h0000);
    tbl[1]  = mk(1'b1, 1'b0, 1, 16'h0000);
    tbl[2]  = mk(1'b1, 1'b1, 1, 16'h0000);
    tbl[3]  = mk(1'b0, 1'b0, 4, 16'h0000);
    tbl[4]  = mk(1'b0, 1'b1, 50, 16'h0001);
    tbl[5]  = mk(1'b0, 1'b0, 5, 16'h0001);
    tbl[6]  = mk(1'b1, 1'b1, 2, 16'h0000);
    tbl[7]  = mk(1'b0, 1'b1, 2, 16'h0000);
    tbl[8]  = mk(1'b0, 1'b1, 1, 16'h0001);
    tbl[9]  = mk(1'b0, 1'b1, 10, 16'h0001);
    tbl[10] = mk(1'b0, 1'b0, 2, 16'h0001);
    for (int v = 0; v < 11; v++) begin
      for (int k = 0; k < tbl[v].hold; k++) tick(tbl[v].rst, tbl[v].inc);
      chk($sformatf("vec%0d", v), count, tbl[v].exp);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) pulse();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("toggle_end", count, 16'h0014);
    chk("toggle_end4", {12'b0, count4}, 16'h0004);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 14; k++) pulse();
    tick(1'b0, 1'b0);
    chk("pre_wrap4", {12'b0, count4}, 16'h000e);
    pulse();
    tick(1'b0, 1'b0);
    chk("all_ones4", {12'b0, count4}, 16'h000f);
    chk("all_ones_wrap4", {15'b0, wrap4}, 16'h0000);
    pulse();
    tick(1'b0, 1'b0);
    chk("rolled4", {12'b0, count4}, 16'h0000);
    chk("rolled_wrap4", {15'b0, wrap4}, 16'h0001);
    chk("rolled16", count, 16'h0010);
    tick(1'b0, 1'b0);
    chk("wrap4_one_cycle", {15'b0, wrap4}, 16'h0000);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 291; k++) pulse();
    tick(1'b0, 1'b0);
    chk("mid_count", count, 16'h0123);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("reset_beats_rise", count, 16'h0000);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
    chk("no_late_inc", count, 16'h0000);
    pulse();
    tick(1'b0, 1'b0);
    chk("post_reset_edge", count, 16'h0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
